// File: rtl/pa_clic_arb_pkg.sv
// Shared types and helpers for the CLIC two-stage arbiter.
package pa_clic_arb_pkg;

    localparam int unsigned CLIC_ID_WIDTH = 12;
    localparam int unsigned RANK_KEY_W    = 10;

    // Rank key: privilege dominates, then level; compared as one unsigned value.
    typedef struct packed {
        logic [1:0] priv;
        logic [7:0] level;
    } rank_key_t;

    // Phase of the 2-cycle interface; PH_HI drives clic_clk_en.
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } arb_phase_e;

    // Left-align the implemented level bits and fill the unimplemented low bits with ones.
    function automatic logic [7:0] expand_level(input logic [7:0] ctl, input int unsigned bits);
        return (ctl << (8 - bits)) | (8'hFF >> bits);
    endfunction

endpackage

// File: rtl/pa_clic_arb_grp.sv
// Combinational N-to-1 rank selector: highest key wins, lower id breaks ties.
module pa_clic_arb_grp
    import pa_clic_arb_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned ID_W = CLIC_ID_WIDTH
) (
    input  logic      [N-1:0]           cand_vld,
    input  rank_key_t [N-1:0]           cand_key,
    input  logic      [N-1:0][ID_W-1:0] cand_id,
    input  logic      [N-1:0]           cand_hv,
    output logic                        win_vld,
    output rank_key_t                   win_key,
    output logic      [ID_W-1:0]        win_id,
    output logic                        win_hv
);

    logic              best_vld;
    rank_key_t         best_key;
    logic [ID_W-1:0]   best_id;
    logic              best_hv;

    // Scan candidates keeping the best-ranked valid one seen so far.
    always_comb begin
        best_vld = 1'b0;
        best_key = '0;
        best_id  = '0;
        best_hv  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_vld[i] && (!best_vld || (cand_key[i] > best_key) ||
                                ((cand_key[i] == best_key) && (cand_id[i] < best_id)))) begin
                best_vld = 1'b1;
                best_key = cand_key[i];
                best_id  = cand_id[i];
                best_hv  = cand_hv[i];
            end
        end
    end

    assign win_vld = best_vld;
    assign win_key = best_key;
    assign win_id  = best_id;
    assign win_hv  = best_hv;

endmodule

// File: rtl/pa_clic_arb_2cycle.sv
// Two-stage registered CLIC arbiter feeding the 2-cycle CPU interface.
// Stage 1 captures per-group winners on clic_clk_en==1 edges, stage 2 captures
// the global winner on clic_clk_en==0 edges. Optional macro PA_CLIC_ARB_THRESH_EN
// enables M-mode mintthresh masking of the driven level.
module pa_clic_arb_2cycle
    import pa_clic_arb_pkg::*;
#(
    parameter int unsigned CLICINTNUM     = 64,
    parameter int unsigned CLICINTCTLBITS = 3,
    parameter int unsigned GRP_SIZE       = 16,
    parameter int unsigned ID_WIDTH       = CLIC_ID_WIDTH
) (
    input  logic                                 forever_cpuclk,
    input  logic                                 cpurst,
    input  logic [CLICINTNUM-1:0]                kid_ip,
    input  logic [CLICINTNUM-1:0]                kid_ie,
    input  logic [CLICINTNUM*CLICINTCTLBITS-1:0] kid_ctl,
    input  logic [CLICINTNUM*2-1:0]              kid_priv,
    input  logic [CLICINTNUM-1:0]                kid_hv,
    input  logic [7:0]                           mintthresh,
    input  logic                                 cpu_int_exit,
    output logic                                 clic_clk_en,
    output logic [ID_WIDTH-1:0]                  clic_int_id,
    output logic [7:0]                           clic_int_il_raw,
    output logic [1:0]                           clic_int_priv,
    output logic                                 clic_int_hv
);

    localparam int unsigned NUM_GRP = CLICINTNUM / GRP_SIZE;

    arb_phase_e phase_q, phase_d;

    // Phase register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) phase_q <= PH_LO;
        else        phase_q <= phase_d;
    end

    // Phase simply alternates every cycle; exit does not disturb it.
    always_comb begin
        phase_d = PH_LO;
        if (phase_q == PH_LO) phase_d = PH_HI;
    end

    assign clic_clk_en = (phase_q == PH_HI);

    logic      [CLICINTNUM-1:0]               src_vld;
    rank_key_t [CLICINTNUM-1:0]               src_key;
    logic      [CLICINTNUM-1:0][ID_WIDTH-1:0] src_id;

    // Per-source candidate flag, rank key and id.
    always_comb begin
        src_vld = '0;
        src_key = '0;
        src_id  = '0;
        for (int unsigned i = 0; i < CLICINTNUM; i++) begin
            src_vld[i]       = kid_ip[i] & kid_ie[i];
            src_key[i].priv  = kid_priv[i*2 +: 2];
            src_key[i].level = expand_level(8'(kid_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS]),
                                            CLICINTCTLBITS);
            src_id[i]        = ID_WIDTH'(i);
        end
    end

    logic      [NUM_GRP-1:0]               grp_nxt_vld;
    rank_key_t [NUM_GRP-1:0]               grp_nxt_key;
    logic      [NUM_GRP-1:0][ID_WIDTH-1:0] grp_nxt_id;
    logic      [NUM_GRP-1:0]               grp_nxt_hv;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        pa_clic_arb_grp #(
            .N    (GRP_SIZE),
            .ID_W (ID_WIDTH)
        ) u_grp (
            .cand_vld (src_vld[g*GRP_SIZE +: GRP_SIZE]),
            .cand_key (src_key[g*GRP_SIZE +: GRP_SIZE]),
            .cand_id  (src_id[g*GRP_SIZE +: GRP_SIZE]),
            .cand_hv  (kid_hv[g*GRP_SIZE +: GRP_SIZE]),
            .win_vld  (grp_nxt_vld[g]),
            .win_key  (grp_nxt_key[g]),
            .win_id   (grp_nxt_id[g]),
            .win_hv   (grp_nxt_hv[g])
        );
    end

    logic      [NUM_GRP-1:0]               grp_vld_q;
    rank_key_t [NUM_GRP-1:0]               grp_key_q;
    logic      [NUM_GRP-1:0][ID_WIDTH-1:0] grp_id_q;
    logic      [NUM_GRP-1:0]               grp_hv_q;

    // Stage 1: register group winners on the high phase; exit wipes the valids.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            grp_vld_q <= '0;
            grp_key_q <= '0;
            grp_id_q  <= '0;
            grp_hv_q  <= '0;
        end else if (cpu_int_exit) begin
            grp_vld_q <= '0;
        end else if (phase_q == PH_HI) begin
            grp_vld_q <= grp_nxt_vld;
            grp_key_q <= grp_nxt_key;
            grp_id_q  <= grp_nxt_id;
            grp_hv_q  <= grp_nxt_hv;
        end
    end

    logic                win_vld;
    rank_key_t           win_key;
    logic [ID_WIDTH-1:0] win_id;
    logic                win_hv;

    pa_clic_arb_grp #(
        .N    (NUM_GRP),
        .ID_W (ID_WIDTH)
    ) u_final (
        .cand_vld (grp_vld_q),
        .cand_key (grp_key_q),
        .cand_id  (grp_id_q),
        .cand_hv  (grp_hv_q),
        .win_vld  (win_vld),
        .win_key  (win_key),
        .win_id   (win_id),
        .win_hv   (win_hv)
    );

    logic [7:0] win_level;

`ifdef PA_CLIC_ARB_THRESH_EN
    // M-mode winners at or below the threshold are reported as no request.
    always_comb begin
        win_level = win_key.level;
        if ((win_key.priv == 2'b11) && (win_key.level <= mintthresh)) win_level = '0;
    end
`else
    logic unused_mintthresh;
    assign unused_mintthresh = ^mintthresh;
    assign win_level         = win_key.level;
`endif

    // Stage 2: register the global winner on the low phase; exit zeroes the request.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            clic_int_id     <= '0;
            clic_int_il_raw <= '0;
            clic_int_priv   <= '0;
            clic_int_hv     <= 1'b0;
        end else if (cpu_int_exit) begin
            clic_int_id     <= '0;
            clic_int_il_raw <= '0;
            clic_int_priv   <= '0;
            clic_int_hv     <= 1'b0;
        end else if (phase_q == PH_LO) begin
            if (win_vld) begin
                clic_int_id     <= win_id;
                clic_int_il_raw <= win_level;
                clic_int_priv   <= win_key.priv;
                clic_int_hv     <= win_hv;
            end else begin
                clic_int_id     <= '0;
                clic_int_il_raw <= '0;
                clic_int_priv   <= '0;
                clic_int_hv     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pa_clic_arb_2cycle.sv
// Self-checking bench for pa_clic_arb_2cycle: global-winner reference model
// with a two-edge pipeline, directed scenarios and randomized traffic.
module tb_pa_clic_arb_2cycle;

    localparam int NUM = 64;
    localparam int CB  = 3;

    logic                forever_cpuclk = 1'b0;
    logic                cpurst         = 1'b1;
    logic [NUM-1:0]      kid_ip         = '0;
    logic [NUM-1:0]      kid_ie         = '0;
    logic [NUM*CB-1:0]   kid_ctl        = '0;
    logic [NUM*2-1:0]    kid_priv       = '0;
    logic [NUM-1:0]      kid_hv         = '0;
    logic [7:0]          mintthresh     = '0;
    logic                cpu_int_exit   = 1'b0;
    logic                clic_clk_en;
    logic [11:0]         clic_int_id;
    logic [7:0]          clic_int_il_raw;
    logic [1:0]          clic_int_priv;
    logic                clic_int_hv;

    pa_clic_arb_2cycle #(
        .CLICINTNUM     (NUM),
        .CLICINTCTLBITS (CB),
        .GRP_SIZE       (16),
        .ID_WIDTH       (12)
    ) dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst          (cpurst),
        .kid_ip          (kid_ip),
        .kid_ie          (kid_ie),
        .kid_ctl         (kid_ctl),
        .kid_priv        (kid_priv),
        .kid_hv          (kid_hv),
        .mintthresh      (mintthresh),
        .cpu_int_exit    (cpu_int_exit),
        .clic_clk_en     (clic_clk_en),
        .clic_int_id     (clic_int_id),
        .clic_int_il_raw (clic_int_il_raw),
        .clic_int_priv   (clic_int_priv),
        .clic_int_hv     (clic_int_hv)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: phase, pending snapshot, visible outputs.
    bit m_phase;
    bit s_v;
    int s_id, s_key;
    bit s_hv;
    int o_il, o_id, o_priv;
    bit o_hv;
    bit o_dc;   // id/priv/hv unconstrained after an exit until the next result

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Global winner over all sources: key = priv*256 + level, lowest id on ties.
    task automatic ref_pick(output bit v, output int id, output int key, output bit hv);
        int k, lvl;
        v = 0; id = 0; key = -1; hv = 0;
        for (int i = 0; i < NUM; i++) begin
            if (kid_ip[i] && kid_ie[i]) begin
                lvl = int'(kid_ctl[i*CB +: CB]) * (2 ** (8 - CB)) + (2 ** (8 - CB) - 1);
                k   = int'(kid_priv[i*2 +: 2]) * 256 + lvl;
                if (k > key) begin
                    v = 1; id = i; key = k; hv = kid_hv[i];
                end
            end
        end
    endtask

    task automatic model_reset();
        m_phase = 0; s_v = 0; s_id = 0; s_key = 0; s_hv = 0;
        o_il = 0; o_id = 0; o_priv = 0; o_hv = 0; o_dc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ":clk_en"}, 32'(clic_clk_en), 32'(m_phase));
        check({tag, ":il"}, 32'(clic_int_il_raw), 32'(o_il));
        if (!o_dc) begin
            check({tag, ":id"}, 32'(clic_int_id), 32'(o_id));
            check({tag, ":priv"}, 32'(clic_int_priv), 32'(o_priv));
            check({tag, ":hv"}, 32'(clic_int_hv), 32'(o_hv));
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then check.
    task automatic tick(input string tag);
        int lvl;
        @(posedge forever_cpuclk);
        if (!cpurst) begin
            if (cpu_int_exit) begin
                s_v = 0; o_il = 0; o_dc = 1;
            end else if (m_phase) begin
                ref_pick(s_v, s_id, s_key, s_hv);
            end else begin
                o_dc = 0;
                if (s_v) begin
                    lvl = s_key % 256;
                    o_id = s_id; o_priv = s_key / 256; o_hv = s_hv; o_il = lvl;
`ifdef PA_CLIC_ARB_THRESH_EN
                    if (o_priv == 3 && lvl <= int'(mintthresh)) o_il = 0;
`endif
                end else begin
                    o_id = 0; o_priv = 0; o_hv = 0; o_il = 0;
                end
            end
            m_phase = !m_phase;
        end
        #1;
        check_all(tag);
    endtask

    task automatic clear_src();
        kid_ip = '0; kid_ie = '0; kid_ctl = '0; kid_priv = '0; kid_hv = '0;
    endtask

    task automatic set_src(input int i, input logic [2:0] ctl, input logic [1:0] p, input logic hv);
        kid_ip[i] = 1'b1; kid_ie[i] = 1'b1;
        kid_ctl[i*CB +: CB] = ctl; kid_priv[i*2 +: 2] = p; kid_hv[i] = hv;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("in_reset");
        #11 cpurst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 4; i++) tick("idle");
        check("idle_il", 32'(clic_int_il_raw), 32'h0);

        // Single source 5.
        set_src(5, 3'b101, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) tick("src5");
        check("src5_il", 32'(clic_int_il_raw), 32'hBF);
        check("src5_id", 32'(clic_int_id), 32'd5);
        check("src5_priv", 32'(clic_int_priv), 32'd3);
        for (int i = 0; i < 2; i++) tick("src5_hold");
        check("src5_hold_il", 32'(clic_int_il_raw), 32'hBF);

        // Equal keys -> lower id; then raise source 40.
        clear_src();
        set_src(3, 3'b010, 2'b11, 1'b0);
        set_src(40, 3'b010, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) tick("tie");
        check("tie_id", 32'(clic_int_id), 32'd3);
        kid_ctl[40*CB +: CB] = 3'b111;
        for (int i = 0; i < 3; i++) tick("raise40");
        check("raise40_id", 32'(clic_int_id), 32'd40);
        check("raise40_il", 32'(clic_int_il_raw), 32'hFF);

        // Privilege dominates level.
        clear_src();
        set_src(7, 3'b111, 2'b01, 1'b0);
        set_src(9, 3'b000, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) tick("privdom");
        check("privdom_id", 32'(clic_int_id), 32'd9);
        check("privdom_il", 32'(clic_int_il_raw), 32'h1F);

        // Threshold at exactly the winner level.
        clear_src();
        set_src(12, 3'b010, 2'b11, 1'b0);
        mintthresh = 8'h5F;
        for (int i = 0; i < 3; i++) tick("thresh");
`ifdef PA_CLIC_ARB_THRESH_EN
        check("thresh_il", 32'(clic_int_il_raw), 32'h00);
`else
        check("thresh_il", 32'(clic_int_il_raw), 32'h5F);
`endif
        check("thresh_id", 32'(clic_int_id), 32'd12);
        mintthresh = 8'h00;

        // Exit on a clic_clk_en==1 edge with source 2 pending.
        clear_src();
        set_src(2, 3'b100, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) tick("pre_exit");
        for (int i = 0; i < 2 && !m_phase; i++) tick("align");
        check("exit_phase", 32'(clic_clk_en), 32'd1);
        cpu_int_exit = 1'b1;
        tick("exit");
        cpu_int_exit = 1'b0;
        check("exit_il", 32'(clic_int_il_raw), 32'h00);
        for (int i = 0; i < 3; i++) tick("post_exit");
        check("post_exit_il", 32'(clic_int_il_raw), 32'h9F);
        check("post_exit_id", 32'(clic_int_id), 32'd2);

        // Asynchronous reset mid-stream.
        #2 cpurst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        tick("rst_hold");
        @(negedge forever_cpuclk) cpurst = 1'b0;
        for (int i = 0; i < 4; i++) tick("after_rst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kid_ip       = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            kid_ie       = {$urandom, $urandom} | {$urandom, $urandom};
            kid_ctl      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kid_priv     = {$urandom, $urandom, $urandom, $urandom};
            kid_hv       = {$urandom, $urandom};
            mintthresh   = 8'($urandom);
            cpu_int_exit = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        cpu_int_exit = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
